clock_divider_multi: RTL and testbench
======================================

# clock_divider_multi

Parametrised multi-channel clock divider, the successor to the fixed single-output divider. Each of CHANNELS channels divides the system clock by its own runtime-programmable divisor and produces a near-50 % divided clock plus a one-cycle tick strobe. Divisors are reprogrammed through a valid/ready port, and updates take effect glitch-free at the channel's period boundary. The block feeds derived timing enables (baud, PWM, scan rates) to downstream logic in the clk domain.

## Interface
- CHANNELS, default 4: number of independent divider channels (1..16).
- DIV_W, default 16: divisor and counter width.
- DEFAULT_DIV, default 2: divisor loaded into every channel at reset; must be ≥ 1.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- en  in  1  global count enable.
- cfg_valid  in  1  divisor update request.
- cfg_ready  out  1  block can accept an update.
- cfg_ch  in  max(1,$clog2(CHANNELS))  target channel index.
- cfg_div  in  DIV_W  new divisor N.
- cfg_err  out  1  one-cycle pulse: rejected update.
- clk_div  out  CHANNELS  divided clock per channel (registered).
- tick  out  CHANNELS  one-cycle strobe per channel period (registered).

## Operation
- Per channel: divisor register div[i], counter cnt[i].
- On every edge with en=1:
  - cnt wraps to 0 when cnt==div-1; otherwise it increments.
  - tick <= (cnt==div-1).
  - clk_div <= (cnt < div - (div>>1)), i.e. high for ceil(N/2) cycles and low for floor(N/2).
- N=1: clk_div is constant 1 and tick=1 every cycle.
- en=0: counters and clk_div hold; tick is forced 0.
- Handshake: an update is accepted on the edge where cfg_valid && cfg_ready. Accepted updates go into a single pending slot (channel, div), and cfg_ready drops to 0 while the slot is full.
- Pending update applies on the target channel's wrap edge (cnt==div-1 with en=1), or on the next edge if en=0.
  - On apply: div <= new value, cnt <= 0, tick for that edge behaves as a normal wrap.
  - The slot clears and cfg_ready returns to 1 on the following cycle.
- Reject rules: cfg_div==0 or cfg_ch ≥ CHANNELS.
  - A rejected update is still accepted (the handshake completes), then dropped.
  - cfg_err pulses the next cycle, cfg_ready stays 1, and no channel changes.
- Other channels are never disturbed by an update to one channel.

## Timing
- Reset values:
  - cnt=0, div=DEFAULT_DIV, clk_div=0, tick=0.
  - cfg_ready=1, cfg_err=0, pending slot empty.
- Reset asserted mid-operation returns every output to its reset value immediately (asynchronously), and a pending update is discarded.
- Latency: outputs reflect the cnt value of the previous cycle.
  - First edge with en=1 after reset: clk_div=1.
  - With N=4: clk_div = 1,1,0,0 repeating; tick=1 on edges 4, 8, ...
- Update latency: cfg_ready is low from the accept edge until 1 cycle after the apply edge. The worst case is old N + 1 cycles.
- The new divisor's first period starts at cnt=0 on the apply edge, so clk_div has no runt pulse.

## Configuration
- CLKDIV_PHASE_ALIGN_EN defined:
  - Adds input port sync (1 bit). When sync=1 on an edge, every channel's cnt is cleared to 0, regardless of en, and ticks are 0 that edge.
  - If a pending apply coincides with sync, the apply also occurs (div updated, cnt=0).
- CLKDIV_PHASE_ALIGN_EN undefined: no sync port and no alignment logic; channels align only via reset.

## Test plan
- Reset then en=1, DEFAULT_DIV=2 → every clk_div toggles 1,0,1,0; tick every 2nd edge; all outputs 0 during rst=0.
- Channel 1 programmed to N=5 while running at N=2 → accepted, cfg_ready low until channel 1 wraps; afterwards clk_div[1]=1,1,1,0,0 with tick every 5 cycles; channel 0 unchanged throughout.
- cfg_div=0, then cfg_ch=CHANNELS → cfg_err pulses once per request, cfg_ready stays 1, no divisor changes.
- en low for 10 cycles mid-period with N=6 → cnt and clk_div frozen, tick=0; counting resumes from the frozen cnt.
- rst asserted with an update pending → pending slot dropped, div=DEFAULT_DIV, cfg_ready=1 after release.
- With CLKDIV_PHASE_ALIGN_EN defined: channels at N=3 and N=4 out of phase, then a sync pulse → both cnt=0; the next edge gives clk_div=1 on both, and the first common tick occurs 12 cycles later.

Source files
------------

// File: rtl/clock_divider_multi_if.sv
// Divisor-update port of clock_divider_multi: a valid/ready request
// carrying (channel, divisor) and a one-cycle reject pulse back.
interface clock_divider_multi_if #(
    parameter int CH_W  = 2,
    parameter int DIV_W = 16
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_div,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_div,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/clock_divider_multi.sv
// Multi-channel runtime-programmable clock divider with tick strobes.
// Optional CLKDIV_PHASE_ALIGN_EN adds a sync input that zeroes every counter.
//
// update slot state | meaning
// SLOT_EMPTY        | no pending update, cfg_ready=1
// SLOT_WAIT         | update held until target channel wraps (or en=0)
// SLOT_DONE         | applied this edge; slot frees on the next edge
module clock_divider_multi #(
    parameter int CHANNELS    = 4,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
`ifdef CLKDIV_PHASE_ALIGN_EN
    input  logic                  sync,
`endif
    clock_divider_multi_if.slave  cfg,
    output logic [CHANNELS-1:0]   clk_div,
    output logic [CHANNELS-1:0]   tick
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [1:0] {SLOT_EMPTY, SLOT_WAIT, SLOT_DONE} slot_t;

    logic [DIV_W-1:0] div_q [CHANNELS];
    logic [DIV_W-1:0] cnt_q [CHANNELS];
    slot_t            slot_q;
    logic [CH_W-1:0]  pend_ch;
    logic [DIV_W-1:0] pend_div;
    logic             ready_q;
    logic             err_q;

    logic [CHANNELS-1:0] wrap;
    logic [CHANNELS-1:0] apply_hit;
    logic                accept;
    logic                bad_req;

    assign cfg.cfg_ready = ready_q;
    assign cfg.cfg_err   = err_q;
    assign accept        = cfg.cfg_valid && ready_q;
    assign bad_req       = (cfg.cfg_div == '0) || (32'(cfg.cfg_ch) >= CHANNELS);

    always_comb begin
        wrap      = '0;
        apply_hit = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            wrap[i]      = (cnt_q[i] == div_q[i] - DIV_W'(1));
            // With en low the counter is frozen, so waiting for a wrap would stall forever.
            apply_hit[i] = (slot_q == SLOT_WAIT) && (pend_ch == CH_W'(i)) && (!en || wrap[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                div_q[i] <= DIV_W'(DEFAULT_DIV);
                cnt_q[i] <= '0;
            end
            clk_div  <= '0;
            tick     <= '0;
            slot_q   <= SLOT_EMPTY;
            pend_ch  <= '0;
            pend_div <= '0;
            ready_q  <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (slot_q)
                SLOT_EMPTY: begin
                    if (accept) begin
                        if (bad_req) begin
                            err_q <= 1'b1;
                        end else begin
                            slot_q   <= SLOT_WAIT;
                            ready_q  <= 1'b0;
                            pend_ch  <= cfg.cfg_ch;
                            pend_div <= cfg.cfg_div;
                        end
                    end
                end
                SLOT_WAIT: begin
                    if (|apply_hit) slot_q <= SLOT_DONE;
                end
                SLOT_DONE: begin
                    slot_q  <= SLOT_EMPTY;
                    ready_q <= 1'b1;
                end
                default: slot_q <= SLOT_EMPTY;
            endcase

            for (int i = 0; i < CHANNELS; i++) begin
                if (en) begin
                    tick[i]    <= wrap[i];
                    clk_div[i] <= (cnt_q[i] < (div_q[i] - (div_q[i] >> 1)));
                    cnt_q[i]   <= wrap[i] ? '0 : cnt_q[i] + DIV_W'(1);
                end else begin
                    tick[i] <= 1'b0;
                end
`ifdef CLKDIV_PHASE_ALIGN_EN
                if (sync) begin
                    cnt_q[i] <= '0;
                    tick[i]  <= 1'b0;
                end
`endif
                if (apply_hit[i]) begin
                    div_q[i] <= pend_div;
                    cnt_q[i] <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_clock_divider_multi.sv
// Randomised self-checking bench for clock_divider_multi against a
// period-position reference model; CLKDIV_PHASE_ALIGN_EN enables the sync test.
module tb_clock_divider_multi;
    localparam int CH  = 3;
    localparam int DW  = 8;
    localparam int DEF = 2;
    localparam int CW  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b0;
    logic [CH-1:0] clk_div;
    logic [CH-1:0] tick;
`ifdef CLKDIV_PHASE_ALIGN_EN
    logic          sync = 1'b0;
`endif

    clock_divider_multi_if #(.CH_W(CW), .DIV_W(DW)) cfg ();

    clock_divider_multi #(.CHANNELS(CH), .DIV_W(DW), .DEFAULT_DIV(DEF)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
`ifdef CLKDIV_PHASE_ALIGN_EN
        .sync    (sync),
`endif
        .cfg     (cfg),
        .clk_div (clk_div),
        .tick    (tick)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: each channel is a position within its current period.
    int            m_n   [CH];
    int            m_pos [CH];
    logic [CH-1:0] m_clk, m_tick;
    logic          m_ready, m_err;
    int            m_busy;   // 0 = slot free, 1 = waiting for boundary, 2 = applied, frees next edge
    int            m_pch, m_pdiv;

    function automatic void model_reset();
        for (int c = 0; c < CH; c++) begin
            m_n[c]   = DEF;
            m_pos[c] = 0;
        end
        m_clk = '0; m_tick = '0; m_ready = 1'b1; m_err = 1'b0; m_busy = 0;
        m_pch = 0; m_pdiv = 0;
    endfunction

    function automatic void model_edge();
        bit [CH-1:0] apply;
        bit          sy;
        bit          acc;
        if (!rst) begin
            model_reset();
            return;
        end
        sy = 1'b0;
`ifdef CLKDIV_PHASE_ALIGN_EN
        sy = sync;
`endif
        acc = cfg.cfg_valid && m_ready;
        for (int c = 0; c < CH; c++)
            apply[c] = (m_busy == 1) && (m_pch == c) && (!en || m_pos[c] == m_n[c] - 1);
        for (int c = 0; c < CH; c++) begin
            if (en) begin
                m_tick[c] = (m_pos[c] == m_n[c] - 1);
                m_clk[c]  = (m_pos[c] < (m_n[c] + 1) / 2);
                m_pos[c]  = (m_pos[c] + 1) % m_n[c];
            end else begin
                m_tick[c] = 1'b0;
            end
            if (sy) begin
                m_pos[c]  = 0;
                m_tick[c] = 1'b0;
            end
            if (apply[c]) begin
                m_n[c]   = m_pdiv;
                m_pos[c] = 0;
            end
        end
        m_err = 1'b0;
        if (m_busy == 2) begin
            m_busy  = 0;
            m_ready = 1'b1;
        end else if (m_busy == 1) begin
            if (apply != 0) m_busy = 2;
        end else if (acc) begin
            if (cfg.cfg_div == 0 || int'(cfg.cfg_ch) >= CH) begin
                m_err = 1'b1;
            end else begin
                m_busy  = 1;
                m_ready = 1'b0;
                m_pch   = int'(cfg.cfg_ch);
                m_pdiv  = int'(cfg.cfg_div);
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic send(input int ch, input int dv);
        cfg.cfg_ch    = ch[CW-1:0];
        cfg.cfg_div   = dv[DW-1:0];
        cfg.cfg_valid = 1'b1;
        step();
        cfg.cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        en = 1'b1;
        #2 rst = 1'b0;
        #1;
        vectors++;
        if ({clk_div, tick, cfg.cfg_ready, cfg.cfg_err} !== {3'b000, 3'b000, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_async got %b expected %b", {clk_div, tick, cfg.cfg_ready, cfg.cfg_err}, 8'b00000010);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++;
            if ({clk_div, tick, cfg.cfg_ready, cfg.cfg_err} !== {3'b000, 3'b000, 1'b1, 1'b0}) begin
                miscompares++;
                $display("FAIL reset_held got %b expected %b", {clk_div, tick, cfg.cfg_ready, cfg.cfg_err}, 8'b00000010);
            end
        end
        rst = 1'b1;
        step();
        vectors++;
        if ({clk_div, tick} !== {3'b111, 3'b000}) begin
            miscompares++;
            $display("FAIL first_edge got %b expected %b", {clk_div, tick}, 6'b111000);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            vectors++;
            if ({clk_div, tick, cfg.cfg_ready, cfg.cfg_err} !== {m_clk, m_tick, m_ready, m_err}) begin
                miscompares++;
                $display("FAIL default_div cyc %0d got %b expected %b", i, {clk_div, tick, cfg.cfg_ready, cfg.cfg_err}, {m_clk, m_tick, m_ready, m_err});
            end
        end
    endtask

    task automatic test_program();
        send(1, 5);
        vectors++;
        if (cfg.cfg_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL program_accept ready got %b expected 0", cfg.cfg_ready);
        end
        for (int i = 0; i < 25; i++) begin
            step();
            vectors++;
            if ({clk_div, tick, cfg.cfg_ready, cfg.cfg_err} !== {m_clk, m_tick, m_ready, m_err}) begin
                miscompares++;
                $display("FAIL program_n5 cyc %0d got %b expected %b", i, {clk_div, tick, cfg.cfg_ready, cfg.cfg_err}, {m_clk, m_tick, m_ready, m_err});
            end
        end
    endtask

    task automatic test_reject();
        send(0, 0);
        vectors++;
        if ({cfg.cfg_ready, cfg.cfg_err} !== 2'b11) begin
            miscompares++;
            $display("FAIL reject_div0 ready/err got %b expected 11", {cfg.cfg_ready, cfg.cfg_err});
        end
        step();
        vectors++;
        if (cfg.cfg_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reject_pulse err got %b expected 0", cfg.cfg_err);
        end
        send(CH, 7);
        vectors++;
        if ({cfg.cfg_ready, cfg.cfg_err} !== 2'b11) begin
            miscompares++;
            $display("FAIL reject_ch ready/err got %b expected 11", {cfg.cfg_ready, cfg.cfg_err});
        end
        for (int i = 0; i < 12; i++) begin
            step();
            vectors++;
            if ({clk_div, tick, cfg.cfg_ready, cfg.cfg_err} !== {m_clk, m_tick, m_ready, m_err}) begin
                miscompares++;
                $display("FAIL reject_after cyc %0d got %b expected %b", i, {clk_div, tick, cfg.cfg_ready, cfg.cfg_err}, {m_clk, m_tick, m_ready, m_err});
            end
        end
    endtask

    task automatic test_enable_hold();
        logic [CH-1:0] frozen;
        int k;
        send(2, 6);
        k = 0;
        while (cfg.cfg_ready !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        vectors++;
        if (cfg.cfg_ready !== 1'b1 || m_n[2] != 6) begin
            miscompares++;
            $display("FAIL hold_setup ready got %b expected 1 (model n=%0d)", cfg.cfg_ready, m_n[2]);
        end
        for (int i = 0; i < 3; i++) step();
        en = 1'b0;
        frozen = m_clk;
        for (int i = 0; i < 10; i++) begin
            step();
            vectors++;
            if ({clk_div, tick} !== {frozen, 3'b000}) begin
                miscompares++;
                $display("FAIL en_low cyc %0d got %b expected %b", i, {clk_div, tick}, {frozen, 3'b000});
            end
        end
        en = 1'b1;
        for (int i = 0; i < 14; i++) begin
            step();
            vectors++;
            if ({clk_div, tick, cfg.cfg_ready, cfg.cfg_err} !== {m_clk, m_tick, m_ready, m_err}) begin
                miscompares++;
                $display("FAIL en_resume cyc %0d got %b expected %b", i, {clk_div, tick, cfg.cfg_ready, cfg.cfg_err}, {m_clk, m_tick, m_ready, m_err});
            end
        end
    endtask

    task automatic test_reset_pending();
        send(2, 7);
        vectors++;
        if (cfg.cfg_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rstpend_accept ready got %b expected 0", cfg.cfg_ready);
        end
        #2 rst = 1'b0;
        model_reset();
        #1;
        vectors++;
        if ({clk_div, tick, cfg.cfg_ready, cfg.cfg_err} !== {3'b000, 3'b000, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL rstpend_async got %b expected %b", {clk_div, tick, cfg.cfg_ready, cfg.cfg_err}, 8'b00000010);
        end
        step();
        step();
        rst = 1'b1;
        for (int i = 0; i < 14; i++) begin
            step();
            vectors++;
            if ({clk_div, tick, cfg.cfg_ready, cfg.cfg_err} !== {m_clk, m_tick, m_ready, m_err}) begin
                miscompares++;
                $display("FAIL rstpend_after cyc %0d got %b expected %b", i, {clk_div, tick, cfg.cfg_ready, cfg.cfg_err}, {m_clk, m_tick, m_ready, m_err});
            end
        end
    endtask

`ifdef CLKDIV_PHASE_ALIGN_EN
    task automatic test_sync();
        int k;
        send(0, 3);
        k = 0;
        while (cfg.cfg_ready !== 1'b1 && k < 20) begin step(); k++; end
        send(1, 4);
        k = 0;
        while (cfg.cfg_ready !== 1'b1 && k < 20) begin step(); k++; end
        for (int i = 0; i < 5; i++) step();
        vectors++;
        if ({clk_div, tick, cfg.cfg_ready, cfg.cfg_err} !== {m_clk, m_tick, m_ready, m_err}) begin
            miscompares++;
            $display("FAIL sync_setup got %b expected %b", {clk_div, tick, cfg.cfg_ready, cfg.cfg_err}, {m_clk, m_tick, m_ready, m_err});
        end
        sync = 1'b1;
        step();
        sync = 1'b0;
        vectors++;
        if (tick !== 3'b000) begin
            miscompares++;
            $display("FAIL sync_edge tick got %b expected 000", tick);
        end
        step();
        vectors++;
        if (clk_div[1:0] !== 2'b11) begin
            miscompares++;
            $display("FAIL sync_next clk_div got %b expected 11", clk_div[1:0]);
        end
        k = 1;
        while (!(tick[0] && tick[1]) && k < 20) begin step(); k++; end
        vectors++;
        if (k != 12) begin
            miscompares++;
            $display("FAIL sync_common_tick got %0d cycles expected 12", k);
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            en            = ($urandom_range(0, 99) < 85);
            cfg.cfg_valid = ($urandom_range(0, 99) < 30);
            cfg.cfg_ch    = CW'($urandom_range(0, 3));
            cfg.cfg_div   = DW'($urandom_range(0, 7));
            step();
            vectors++;
            if ({clk_div, tick, cfg.cfg_ready, cfg.cfg_err} !== {m_clk, m_tick, m_ready, m_err}) begin
                miscompares++;
                $display("FAIL random cyc %0d got %b expected %b", i, {clk_div, tick, cfg.cfg_ready, cfg.cfg_err}, {m_clk, m_tick, m_ready, m_err});
            end
        end
        cfg.cfg_valid = 1'b0;
        en = 1'b1;
    endtask

    initial begin
        cfg.cfg_valid = 1'b0;
        cfg.cfg_ch    = '0;
        cfg.cfg_div   = '0;
        test_reset();
        test_program();
        test_reject();
        test_enable_hold();
        test_reset_pending();
`ifdef CLKDIV_PHASE_ALIGN_EN
        test_sync();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
